// File: rtl/babbage_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3) with start/done/rdy handshake.
// Optional sticky overflow output enabled by defining BABBAGE_BCD_OVF_EN.
module babbage_bcd_conv #(
    parameter int BIN_WIDTH = 12,
    parameter int DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done,
    output logic                  rdy
`ifdef BABBAGE_BCD_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]     work_q, work_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;

    logic [BCD_W-1:0]     work_adj;
    logic [BCD_W-1:0]     work_shift;
    logic                 carry_out;

    // Add-3 correction per digit; a digit never exceeds 9 here, so 4 bits suffice.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        {carry_out, work_shift} = {work_adj, sh_q[BIN_WIDTH-1]};
    end

`ifdef BABBAGE_BCD_OVF_EN
    logic flag_q, flag_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d = state_q;
        sh_d    = sh_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
`ifdef BABBAGE_BCD_OVF_EN
        flag_d  = flag_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    work_d  = '0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                    state_d = ST_CONV;
`ifdef BABBAGE_BCD_OVF_EN
                    flag_d  = 1'b0;
`endif
                end
            end
            ST_CONV: begin
                sh_d   = sh_q << 1;
                work_d = work_shift;
                cnt_d  = cnt_q - 1'b1;
`ifdef BABBAGE_BCD_OVF_EN
                flag_d = flag_q | carry_out;
`endif
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = work_shift;
                    state_d = ST_DONE;
`ifdef BABBAGE_BCD_OVF_EN
                    ovf_d   = flag_q | carry_out;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

`ifdef BABBAGE_BCD_OVF_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Top-digit carry is silently discarded in this build.
    logic unused_carry;
    assign unused_carry = carry_out;
`endif

    assign bcd  = bcd_q;
    assign done = (state_q == ST_DONE);
    assign rdy  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_babbage_bcd_conv.sv
// Self-checking bench: a 4-digit and a 3-digit converter share stimulus and are
// compared cycle by cycle against a decimal-arithmetic reference model.
module tb_babbage_bcd_conv;

    localparam int BW = 12;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [11:0] bin;
    logic [15:0] bcd4;
    logic [11:0] bcd3;
    logic        done4, rdy4, done3, rdy3;
    logic        ovf3;

    int n_checks;
    int n_fail;

    logic [15:0] last4;
    logic [11:0] last3;
    logic        last_ovf;

    babbage_bcd_conv #(.BIN_WIDTH(BW), .DIGITS(4)) dut4 (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (start),
        .bin    (bin),
        .bcd    (bcd4),
        .done   (done4),
        .rdy    (rdy4)
`ifdef BABBAGE_BCD_OVF_EN
        ,
        .ovf    ()
`endif
    );

    babbage_bcd_conv #(.BIN_WIDTH(BW), .DIGITS(3)) dut3 (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (start),
        .bin    (bin),
        .bcd    (bcd3),
        .done   (done3),
        .rdy    (rdy3)
`ifdef BABBAGE_BCD_OVF_EN
        ,
        .ovf    (ovf3)
`endif
    );

`ifndef BABBAGE_BCD_OVF_EN
    assign ovf3 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by repeated division, packed 4 bits per digit.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic compare(input string name, input int cyc,
                           input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, obs, exp);
        end
    endtask

    // One conversion; optionally injects a second start at CONV cycle inj_cyc.
    task automatic run_conv(input string name, input logic [11:0] v,
                            input int inj_cyc, input logic [11:0] inj_val,
                            input bit b2b);
        logic [15:0] e4;
        logic [15:0] tmp;
        logic [11:0] e3;
        logic        eo;
        logic [33:0] exp_v;
        e4  = to_bcd(int'(v));
        tmp = to_bcd(int'(v) % 1000);
        e3  = tmp[11:0];
`ifdef BABBAGE_BCD_OVF_EN
        eo  = (v > 12'd999);
`else
        eo  = 1'b0;
`endif
        if (!b2b) @(negedge clk);
        compare({name, "_rdy_before"}, 0,
                {33'd0, rdy4 & rdy3}, {33'd0, 1'b1});
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        for (int c = 1; c <= BW + 2; c++) begin
            @(negedge clk);
            start = (c == inj_cyc);
            bin   = (c == inj_cyc) ? inj_val : 12'($urandom);
            if (c <= BW) begin
                exp_v = {1'b0, 1'b0, last4, 1'b0, 1'b0, last3, last_ovf};
            end else if (c == BW + 1) begin
                last4    = e4;
                last3    = e3;
                last_ovf = eo;
                exp_v = {1'b1, 1'b0, last4, 1'b1, 1'b0, last3, last_ovf};
            end else begin
                exp_v = {1'b0, 1'b1, last4, 1'b0, 1'b1, last3, last_ovf};
            end
            compare(name, c, {done4, rdy4, bcd4, done3, rdy3, bcd3, ovf3}, exp_v);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        start  = 1'b0;
        bin    = '0;
        last4 = '0; last3 = '0; last_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            compare("reset_idle", c, {done4, rdy4, bcd4, done3, rdy3, bcd3, ovf3},
                    {1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 12'h000, 1'b0});
        end
    endtask

    task automatic test_zero();
        run_conv("zero", 12'd0, 0, 12'd0, 1'b0);
    endtask

    task automatic test_engine_chain();
        int f_out [4] = '{5, 10, 19, 32};
        foreach (f_out[i]) run_conv("engine_chain", 12'(f_out[i]), 0, 12'd0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_conv("overlap_4095", 12'd4095, 5, 12'd7, 1'b0);
        run_conv("after_overlap_7", 12'd7, 0, 12'd0, 1'b0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        start = 1'b1;
        bin   = 12'd1234;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        arst_n = 1'b0;
        last4 = '0; last3 = '0; last_ovf = 1'b0;
        #1;
        compare("abort_in_reset", 6, {done4, rdy4, bcd4, done3, rdy3, bcd3, ovf3},
                {1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 12'h000, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            compare("abort_no_done", c, {done4, rdy4, bcd4, done3, rdy3, bcd3, ovf3},
                    {1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 12'h000, 1'b0});
        end
        run_conv("after_abort_999", 12'd999, 0, 12'd0, 1'b0);
    endtask

    task automatic test_truncation();
        run_conv("trunc_1234", 12'd1234, 0, 12'd0, 1'b0);
        run_conv("trunc_999", 12'd999, 0, 12'd0, 1'b0);
        run_conv("trunc_1000", 12'd1000, 0, 12'd0, 1'b0);
        run_conv("max_4095", 12'd4095, 0, 12'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_conv("random", 12'($urandom_range(0, 4095)), 0, 12'd0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_conv("b2b_first", 12'($urandom_range(0, 4095)), 0, 12'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_conv("b2b_next", 12'($urandom_range(0, 4095)), 0, 12'd0, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_zero();
        test_engine_chain();
        test_start_ignored();
        test_reset_abort();
        test_truncation();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/babbage_bcd_conv.md
# babbage_bcd_conv

Sequential binary-to-BCD converter (shift-add-3 / double dabble) sitting directly downstream of the Babbage difference-equation engine. It captures the engine's binary result `f_out` when `done` pulses and produces packed BCD digits for the seven-segment display multiplexer. It uses the same start/done/rdy handshake and IDLE/work/DONE control style as the engine, so the engine's `done` can drive this block's `start` directly.

## Interface
- `BIN_WIDTH`, default 12: width of the binary input; matches engine `OUT_WIDTH` for `IN_WIDTH`=5.
- `DIGITS`, default 4: number of BCD digits produced; must be ≥1.
- `clk`  in  1  system clock, all state on rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request conversion; sampled only while `rdy`=1.
- `bin`  in  BIN_WIDTH  unsigned binary value, sampled on the `start` cycle only.
- `bcd`  out  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], with digit 0 least significant.
- `done`  out  1  one-cycle pulse when `bcd` holds a fresh result.
- `rdy`  out  1  high while idle and able to accept `start`.
- `ovf`  out  1  present only with `BABBAGE_BCD_OVF_EN`; see Configuration.

## Operation
- States:
  - IDLE (`rdy`=1).
  - CONV: shifting.
  - DONE (`done`=1).
- Illegal or unknown state goes to IDLE.
- IDLE:
  - With `start`=1: load `bin` into the shift register, clear the BCD working register, load the bit counter with BIN_WIDTH, and go to CONV.
  - With `start`=0: hold.
- CONV, each cycle:
  - Add 3 to every working digit ≥5.
  - Then shift {working BCD, shift reg} left by one; the shift-reg MSB enters BCD bit 0.
  - Decrement the counter.
  - When the counter is 1, go to DONE and load the output register `bcd` with the post-shift working value in the same edge.
- DONE: go to IDLE unconditionally.
- `start` outside IDLE is ignored, with no queueing.
- `bcd` is an output register, changed only on the CONV→DONE edge. It holds the last result through IDLE and the next CONV, so the display never shows partial values.
- Arithmetic is unsigned. Each digit add is 4-bit and never exceeds 9+3 before the shift.
- If 10^DIGITS−1 < 2^BIN_WIDTH−1: the carry shifted out of the top digit is discarded, and `bcd` = `bin` mod 10^DIGITS.
- Reset values:
  - State IDLE.
  - `bcd`=0, `done`=0, `rdy`=1, `ovf`=0.
  - Working registers and counter = 0.
- Reset mid-operation aborts immediately. The result is not delivered and no `done` is issued.

## Timing
- Let `start` be sampled at edge k:
  - CONV occupies cycles k+1 … k+BIN_WIDTH.
  - `bcd` and `done` are valid in cycle k+BIN_WIDTH+1.
  - `rdy` returns at k+BIN_WIDTH+2.
- Latency start→done is BIN_WIDTH+1 cycles; for default 12, done appears 13 edges after start.
- Throughput is one conversion per BIN_WIDTH+2 cycles.
- `rdy` is low from k+1 through the DONE cycle.
- `done` is exactly one cycle wide.
- Engine hookup: engine `done` → `start`, engine `f_out` → `bin`. The engine's output is stable in its DONE cycle, which is the sample cycle here.

## Configuration
- `BABBAGE_BCD_OVF_EN` defined:
  - Port `ovf` exists.
  - A sticky flag is cleared on accepted `start` and set whenever a 1 is shifted out of the top digit during CONV.
  - `ovf` is registered with `bcd` on the CONV→DONE edge and held until the next result.
  - `ovf`=1 means `bin` > 10^DIGITS−1; `bcd` is still the mod value.
- `BABBAGE_BCD_OVF_EN` undefined: no `ovf` port, no flag logic, and truncation is silent.

## Test plan
- After reset, no start → `rdy`=1, `done`=0, `bcd`=0x0000 held for 20 cycles.
- `bin`=0 → after 13 cycles `done` pulses once with `bcd`=0x0000, `rdy` back next cycle.
- Engine chain with n=0,1,2,3 (`f_out`=5, 10, 19, 32) → `bcd`=0x0005, 0x0010, 0x0019, 0x0032 respectively.
- `bin`=4095, then a second `start` with `bin`=7 at CONV cycle 5 → `bcd`=0x4095 at latency 13; the second start is ignored and only one `done` is seen. Next a `start` in IDLE with `bin`=7 → 0x0007.
- `arst_n` low at CONV cycle 6 of `bin`=1234 → `bcd`=0, no `done`. After release, `bin`=999 → 0x0999.
- DIGITS=3, `BABBAGE_BCD_OVF_EN` defined:
  - `bin`=1234 → `bcd`=0x234, `ovf`=1.
  - Then `bin`=999 → `bcd`=0x999, `ovf`=0.
